data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Multi-cycle data-memory responder for the RV32IM pipelined CPU, answering the load/store requests issued by the MEM stage. Holds a word-organised RAM, performs byte/halfword/word accesses with RV32 sign/zero extension, and stalls the pipeline through `BUSYWAIT` for a programmable access latency. It is the memory-side end of the CPU's MEM-stage request/stall interface.

## Interface
- `ADDR_WIDTH`, 8: word-index bits; RAM depth is 2^ADDR_WIDTH 32-bit words (default 1 KiB)
- `LATENCY`, 2: access cycles with `BUSYWAIT` high, legal range 1..15
- `CLK`  in  1  clock; all state changes on the rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `MEM_READ`  in  1  load request, held by the CPU until `BUSYWAIT` falls
- `MEM_WRITE`  in  1  store request, held the same way
- `FUNCT3`  in  3  access type: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010
- `ADDRESS`  in  32  byte address
- `WRITE_DATA`  in  32  store data; lanes taken from the low bits
- `READ_DATA`  out  32  extended load result
- `BUSYWAIT`  out  1  pipeline stall request
- `MISALIGNED`  out  1  one-cycle pulse on a rejected misaligned access (with `DMEM_ALIGN_CHECK_EN` only)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if `MEM_READ|MEM_WRITE`, assert `BUSYWAIT` combinationally in the same cycle. At the edge, latch address, funct3, data and direction; load the counter with LATENCY-1; go to ACCESS.
- ACCESS: `BUSYWAIT`=1. The counter decrements each edge. On the edge where the counter is 0, perform the RAM operation, register `READ_DATA` (loads only; stores leave it unchanged), and go to DONE.
- DONE: `BUSYWAIT`=0 and `READ_DATA` valid for this cycle. The CPU's still-held request is ignored. Go to IDLE unconditionally.
- Word index is `ADDRESS[ADDR_WIDTH+1:2]`; higher address bits are ignored, so addresses wrap modulo the RAM size.
- Stores write only the addressed lanes:
  - SB: 1 lane selected by `ADDRESS[1:0]`.
  - SH: 2 lanes selected by `ADDRESS[1]`.
  - SW: all 4 lanes.
- Loads:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined FUNCT3 codes (011, 110, 111) read as LW and write as SW.
- `MEM_READ` and `MEM_WRITE` both high: treated as a write.
- Reset mid-operation:
  - Aborts the access; any pending store is not committed.
  - State returns to IDLE.
  - RAM contents are not cleared.
- Reset values: `READ_DATA`=0, `BUSYWAIT`=0 (with no request present), `MISALIGNED`=0, state IDLE, counter 0.

## Timing
- A request accepted in cycle N causes `BUSYWAIT` to be high in cycles N..N+LATENCY.
- DONE falls in cycle N+LATENCY+1, which is the cycle the CPU advances.
- Back-to-back requests: the next request can be accepted in cycle N+LATENCY+2.
- With LATENCY=1: `BUSYWAIT` is high for 2 cycles.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A halfword access with `ADDRESS[0]`=1, or a word access with `ADDRESS[1:0]`≠0, goes IDLE→DONE directly.
  - `BUSYWAIT` is high for that one cycle only.
  - `MISALIGNED` pulses in the DONE cycle.
  - There is no RAM write, and `READ_DATA` is unchanged.
- Undefined:
  - The offending low address bits are forced to zero and the access proceeds as aligned.
  - `MISALIGNED` is tied to 0.

## Structure
- Shared package `dmem_pkg`: FUNCT3 load/store constants, state enum, `LATENCY` bound constant.
- Sub-module `dmem_lane_align`: combinational byte-enable generation, store-data replication, and load extract/extend, taking funct3 and `ADDRESS[1:0]`.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10, then LW from 0x10 (LATENCY=2) -> `BUSYWAIT` high for 3 cycles each; `READ_DATA`=0xDEADBEEF in DONE.
- SB 0x80 to 0x13, then LB 0x13 and LBU 0x13 -> 0xFFFFFF80 and 0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH 0x1234 to 0x22, then LH 0x22 -> 0x00001234; LHU 0x20 -> 0x00000000.
- RESET pulsed during the ACCESS phase of SW 0x5 to 0x30 -> `BUSYWAIT`=0 immediately; a later LW 0x30 returns the prior content, not 0x5.
- With `DMEM_ALIGN_CHECK_EN`, LW 0x31 -> `BUSYWAIT` high for 1 cycle and `MISALIGNED` pulses. Without it, LW 0x31 returns the word at 0x30.
- Address wrap with ADDR_WIDTH=8: SW 0xA5A5A5A5 to 0x400, then LW 0x000 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - RV32 load/store FUNCT3 encodings
//   - controller state enum and access-size enum
//   - LAT_MAX: upper bound on the LATENCY parameter
//   - f3_size(): maps a FUNCT3 code and direction to an access size
package dmem_pkg;

    localparam int LAT_MAX = 15;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Codes that are not a defined byte/half access fall back to a word access.
    function automatic size_t f3_size(input logic [2:0] f3, input logic is_store);
        size_t sz;
        sz = SZ_W;
        if (is_store) begin
            if (f3 == F3_B)      sz = SZ_B;
            else if (f3 == F3_H) sz = SZ_H;
        end else begin
            if (f3 == F3_B || f3 == F3_BU)      sz = SZ_B;
            else if (f3 == F3_H || f3 == F3_HU) sz = SZ_H;
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
//   funct3    in   access type (RV32 load/store encoding)
//   is_store  in   1 = store, 0 = load
//   offs      in   byte offset within the word (already aligned to the size)
//   wdata     in   raw store data, lanes taken from the low bits
//   rword     in   current RAM word
//   be        out  byte enables for the store
//   wdata_rep out  store data replicated onto every candidate lane
//   rdata_ext out  extracted and sign/zero-extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  offs,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    size_t       sz;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        uns;

    assign sz    = f3_size(funct3, is_store);
    assign rbyte = rword[{offs, 3'b000} +: 8];
    assign rhalf = offs[1] ? rword[31:16] : rword[15:0];
    assign uns   = funct3[2];   // LBU / LHU

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
        case (sz)
            SZ_B: begin
                be        = 4'b0001 << offs;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{rbyte[7] & ~uns}}, rbyte};
            end
            SZ_H: begin
                be        = offs[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{rhalf[15] & ~uns}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: multi-cycle word-organised data RAM for the MEM stage.
// Holds BUSYWAIT high from the request cycle through LATENCY access cycles,
// then spends one DONE cycle with BUSYWAIT low and READ_DATA valid.
//   CLK, RESET           clock, asynchronous active-high reset
//   MEM_READ, MEM_WRITE  request (write wins when both are high)
//   FUNCT3, ADDRESS      access type and byte address
//   WRITE_DATA           store data
//   READ_DATA            registered, extended load result
//   BUSYWAIT             stall request to the pipeline
//   MISALIGNED           one-cycle pulse on a rejected misaligned access
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- reject misaligned half/word
// accesses instead of silently aligning them.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = 4;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [1:0]            offs_q;
    logic [2:0]            f3_q;
    logic [31:0]           wd_q;
    logic                  we_q;
    logic [31:0]           mem [DEPTH];

    logic                  req, take, mis_go, commit;
    size_t                 size_in;
    logic [1:0]            offs_in;
    logic [3:0]            be;
    logic [31:0]           wd_rep, rword, rdata_ext;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH+2];

    assign req     = MEM_READ | MEM_WRITE;
    assign size_in = f3_size(FUNCT3, MEM_WRITE);
    assign commit  = (state == ST_ACCESS) && (cnt == '0);
    assign rword   = mem[idx_q];

    // Low address bits below the access size are dropped: misaligned
    // accesses either proceed as aligned or are rejected before latching.
    always_comb begin
        offs_in = ADDRESS[1:0];
        if (size_in == SZ_H)      offs_in = {ADDRESS[1], 1'b0};
        else if (size_in == SZ_W) offs_in = 2'b00;
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_go = ((size_in == SZ_H) && ADDRESS[0]) ||
                    ((size_in == SZ_W) && (ADDRESS[1:0] != 2'b00));
`else
    assign mis_go = 1'b0;
`endif

    dmem_lane_align u_align (
        .funct3    (f3_q),
        .is_store  (we_q),
        .offs      (offs_q),
        .wdata     (wd_q),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wd_rep),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_nx = state;
        BUSYWAIT = 1'b0;
        take     = 1'b0;
        case (state)
            ST_IDLE: if (req) begin
                BUSYWAIT = 1'b1;
                take     = 1'b1;
                state_nx = mis_go ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                BUSYWAIT = 1'b1;
                if (cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;   // still-held request is ignored
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            offs_q     <= '0;
            f3_q       <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            READ_DATA  <= '0;
            MISALIGNED <= 1'b0;
        end else begin
            state      <= state_nx;
            MISALIGNED <= take & mis_go;
            if (take) begin
                idx_q  <= ADDRESS[ADDR_WIDTH+1:2];
                offs_q <= offs_in;
                f3_q   <= FUNCT3;
                wd_q   <= WRITE_DATA;
                we_q   <= MEM_WRITE;
                cnt    <= CW'(LATENCY - 1);
            end else if (state == ST_ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit && !we_q) READ_DATA <= rdata_ext;
        end
    end

    // RAM has no reset; an aborted store never reaches commit because
    // RESET forces the state back to IDLE asynchronously.
    always_ff @(posedge CLK) begin
        if (commit && we_q && !RESET) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mem[idx_q][8*l +: 8] <= wd_rep[8*l +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS, WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT, MISALIGNED;

    int checks = 0;
    int errors = 0;

    data_memory_ctrl #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .FUNCT3     (FUNCT3),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSYWAIT   (BUSYWAIT),
        .MISALIGNED (MISALIGNED)
    );

    always #5 CLK = ~CLK;

    // Drives one request at a negedge, holds it until BUSYWAIT falls (bounded),
    // and returns the number of busy cycles plus the DONE-cycle outputs.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int busy, output logic [31:0] rdata, output logic mis);
        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd;
        busy = 0;
        while (1) begin
            #1;
            if (!BUSYWAIT) break;
            busy++;
            if (busy > 40) break;
            @(negedge CLK);
        end
        rdata = READ_DATA;
        mis   = MISALIGNED;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        FUNCT3 = 3'b010; ADDRESS = '0; WRITE_DATA = '0;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (READ_DATA !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", READ_DATA); end
        checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSYWAIT); end
        checks++; if (MISALIGNED !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", MISALIGNED); end
        @(negedge CLK); RESET = 1'b0;
    endtask

    task automatic test_word();
        int b; logic [31:0] r; logic m;
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, b, r, m);
        checks++; if (b !== 3) begin errors++; $display("FAIL sw_busy: got %0d expected 3", b); end
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, b, r, m);
        checks++; if (b !== 3) begin errors++; $display("FAIL lw_busy: got %0d expected 3", b); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", r); end
    endtask

    task automatic test_byte();
        int b; logic [31:0] r; logic m;
        access(1'b0, 1'b1, 3'b000, 32'h13, 32'h12345680, b, r, m);
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL sb_keeps_rdata: got %h expected deadbeef", r); end
        access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, b, r, m);
        checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h expected ffffff80", r); end
        access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, b, r, m);
        checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", r); end
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, b, r, m);
        checks++; if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h expected 80adbeef", r); end
        access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, b, r, m);
        checks++; if (r !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_lane0: got %h expected ffffffef", r); end
        access(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, b, r, m);
        checks++; if (r !== 32'h000000BE) begin errors++; $display("FAIL lbu_lane1: got %h expected 000000be", r); end
    endtask

    task automatic test_half();
        int b; logic [31:0] r; logic m;
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, b, r, m);
        access(1'b0, 1'b1, 3'b001, 32'h22, 32'hABCD1234, b, r, m);
        access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, b, r, m);
        checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL lh_hi: got %h expected 00001234", r); end
        access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, b, r, m);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL lhu_lo: got %h expected 00000000", r); end
        access(1'b0, 1'b1, 3'b001, 32'h20, 32'h00008001, b, r, m);
        access(1'b1, 1'b0, 3'b001, 32'h20, 32'h0, b, r, m);
        checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sign: got %h expected ffff8001", r); end
        access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, b, r, m);
        checks++; if (r !== 32'h00008001) begin errors++; $display("FAIL lhu_zero: got %h expected 00008001", r); end
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, b, r, m);
        checks++; if (r !== 32'h12348001) begin errors++; $display("FAIL lw_halves: got %h expected 12348001", r); end
    endtask

    task automatic test_rw_both();
        int b; logic [31:0] r; logic m;
        access(1'b1, 1'b1, 3'b010, 32'h40, 32'h00000077, b, r, m);
        checks++; if (r !== 32'h12348001) begin errors++; $display("FAIL both_is_write_rdata: got %h expected 12348001", r); end
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, b, r, m);
        checks++; if (r !== 32'h00000077) begin errors++; $display("FAIL both_is_write_mem: got %h expected 00000077", r); end
        access(1'b1, 1'b0, 3'b111, 32'h10, 32'h0, b, r, m);
        checks++; if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL undef_f3_lw: got %h expected 80adbeef", r); end
    endtask

    task automatic test_reset_abort();
        int b; logic [31:0] r; logic m;
        access(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, b, r, m);
        @(negedge CLK);
        MEM_WRITE = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h30; WRITE_DATA = 32'h5;
        @(negedge CLK);     // first ACCESS cycle
        #1;
        RESET = 1'b1; MEM_WRITE = 1'b0;
        #1;
        checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", BUSYWAIT); end
        checks++; if (READ_DATA !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 00000000", READ_DATA); end
        @(negedge CLK); RESET = 1'b0;
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, b, r, m);
        checks++; if (b !== 3) begin errors++; $display("FAIL abort_lw_busy: got %0d expected 3", b); end
        checks++; if (r !== 32'h11223344) begin errors++; $display("FAIL abort_no_commit: got %h expected 11223344", r); end
    endtask

    task automatic test_misaligned();
        int b; logic [31:0] r; logic m;
        access(1'b1, 1'b0, 3'b010, 32'h31, 32'h0, b, r, m);
`ifdef DMEM_ALIGN_CHECK_EN
        checks++; if (b !== 1) begin errors++; $display("FAIL mis_busy: got %0d expected 1", b); end
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", m); end
`else
        checks++; if (b !== 3) begin errors++; $display("FAIL mis_busy: got %0d expected 3", b); end
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", m); end
`endif
        checks++; if (r !== 32'h11223344) begin errors++; $display("FAIL mis_data: got %h expected 11223344", r); end
    endtask

    task automatic test_wrap();
        int b; logic [31:0] r; logic m;
        access(1'b0, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, b, r, m);
        access(1'b1, 1'b0, 3'b010, 32'h000, 32'h0, b, r, m);
        checks++; if (r !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap: got %h expected a5a5a5a5", r); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_rw_both();
        test_reset_abort();
        test_misaligned();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
